spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- Command sequencer behind spi_slave: consumes one byte per SSEL frame (cmd/cmd_valid) and drives the byte-wide response that spi_slave shifts out on the next frame.
- Turns the frame stream into register read/write transactions on a simple req/ack register bus, one frame per command or data byte.
- Provides bus timeout, overrun detection and an internal status register.

Parameters:
- ADDR_W, 7, register bus address width; must be 7 (fills cmd[6:0]).
- ACK_TIMEOUT, 64, clk cycles to wait for bus_ack before aborting (≥2).
- ERR_BYTE, 8'hEE, response byte loaded on bus timeout.
- STATUS_ADDR, 7'h7F, address decoded internally as the status register; never issued on the bus.

Ports:
- clk  in  1  system clock, same clock as spi_slave.
- rst  in  1  synchronous, active-high reset.
- cmd  in  8  received byte from spi_slave.
- cmd_valid  in  1  one-cycle strobe; cmd is valid this cycle.
- response  out  8  byte sampled by spi_slave at the next cmd_valid; registered.
- bus_req  out  1  transaction request; held until bus_ack.
- bus_we  out  1  1 = write, 0 = read; stable while bus_req is high.
- bus_addr  out  7  register address; stable while bus_req is high.
- bus_wdata  out  8  write data; stable while bus_req is high.
- bus_ack  in  1  one-cycle completion strobe; ignored when bus_req is low.
- bus_rdata  in  8  read data; valid in the bus_ack cycle.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky; set by a bus timeout.
- err_overrun  out  1  sticky; set when a byte is dropped.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: response=8'h00, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, busy=0, err_timeout=0, err_overrun=0; state=IDLE; timeout counter=0.
- Command byte format: cmd[7]=1 is a write, 0 is a read; cmd[6:0] is the address.
- States: IDLE, WAIT_DATA, BUS_WR, BUS_RD.
- IDLE, cmd_valid with write: latch the address, go to WAIT_DATA.
- IDLE, cmd_valid with read, address != STATUS_ADDR: go to BUS_RD next cycle with bus_req=1, bus_we=0.
- IDLE, cmd_valid with read of STATUS_ADDR: response <= {6'b0, err_overrun, err_timeout} the next cycle; then clear both flags in the same edge, with a new set event winning over the clear. No bus cycle; stays in IDLE.
- WAIT_DATA, cmd_valid: bus_wdata <= cmd, bus_req=1, bus_we=1, go to BUS_WR. The byte is always data, never decoded as a command.
- WAIT_DATA on a write to STATUS_ADDR: consume the data byte, no bus cycle, return to IDLE, response unchanged.
- BUS_WR/BUS_RD, bus_ack: bus_req <= 0 on the following edge and return to IDLE.
  - On a read, response <= bus_rdata in the same edge.
  - On a write, response is unchanged.
- Latency: cmd_valid to bus_req is 1 cycle. bus_ack to response update and return to IDLE is 1 edge.
- Timeout: the counter is cleared on bus_req rising and increments each cycle in BUS_*. At count == ACK_TIMEOUT-1 without ack: drop bus_req, set err_timeout, response <= ERR_BYTE (read) or unchanged (write), go to IDLE.
- bus_ack in the same cycle as the timeout terminal count: the ack wins; no error.
- cmd_valid while in BUS_WR/BUS_RD: the byte is dropped, err_overrun=1, and the transaction continues. If cmd_valid coincides with bus_ack, the byte is still dropped.
- Read pipelining: the read result appears on the frame after the read command. That frame's own byte is decoded as a new command.
- WAIT_DATA has no timeout; only rst exits it without a byte.
- rst mid-transaction: bus_req drops on the next edge, and any pending write data is discarded.

Optional Feature:
- Macro: SPI_REG_CTRL_WR_ECHO_EN.
- Defined: on write completion (bus_ack in BUS_WR), response <= ~bus_wdata, so the host verifies the write on the next frame. A write timeout loads ERR_BYTE.
- Undefined: writes leave response unchanged, and a write timeout sets only err_timeout.

Test Plan:
- Write: cmd 8'h85 then 8'h3C, bus_ack after 3 cycles -> bus_req with bus_we=1, bus_addr=7'h05, bus_wdata=8'h3C; single transaction; busy low after ack; response 8'h00 (8'hC3 with ECHO_EN).
- Read: cmd 8'h12, bus_rdata=8'hA7 with ack after 1 cycle -> bus_addr=7'h12, bus_we=0; response=8'hA7 one edge after ack.
- Timeout: cmd 8'h20, no ack -> bus_req drops after exactly 64 cycles; err_timeout=1; response=8'hEE. Then cmd 8'h7F -> response=8'h01 and err_timeout cleared.
- Overrun: cmd 8'h10 followed by cmd 8'h11 while bus_req is high -> one bus transaction only; err_overrun=1. A following status read returns 8'h02.
- Collision: bus_ack on the same cycle as the timeout terminal count -> no error; response=bus_rdata.
- Reset: rst asserted in WAIT_DATA and again in BUS_RD -> all outputs at reset values next edge; the following cmd 8'h85 is treated as a command, not data.

Source files
------------

// File: rtl/spi_reg_ctrl_if.sv
// Byte-stream and register-bus signals between spi_slave, spi_reg_ctrl and the register bus.
interface spi_reg_ctrl_if #(parameter int ADDR_W = 7);
  logic [7:0]        cmd;
  logic              cmd_valid;
  logic [7:0]        response;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_ack;
  logic [7:0]        bus_rdata;
  logic              busy;
  logic              err_timeout;
  logic              err_overrun;

  modport slave (
    input  cmd, cmd_valid, bus_ack, bus_rdata,
    output response, bus_req, bus_we, bus_addr, bus_wdata, busy, err_timeout, err_overrun
  );

  modport master (
    output cmd, cmd_valid, bus_ack, bus_rdata,
    input  response, bus_req, bus_we, bus_addr, bus_wdata, busy, err_timeout, err_overrun
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: one byte per frame into req/ack register reads/writes, with status, timeout, overrun.
// Optional macro SPI_REG_CTRL_WR_ECHO_EN: write completion loads ~wdata into response, write timeout loads ERR_BYTE.
module spi_reg_ctrl #(
  parameter int         ADDR_W      = 7,
  parameter int         ACK_TIMEOUT = 64,
  parameter logic [7:0] ERR_BYTE    = 8'hEE,
  parameter logic [6:0] STATUS_ADDR = 7'h7F
) (
  input logic             clk,
  input logic             rst,
  spi_reg_ctrl_if.slave   io
);
  localparam int CNT_W = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, BUS_WR, BUS_RD} state_t;

  state_t            state_q, state_d;
  logic [7:0]        response_q, response_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              to_q, to_d;
  logic              ov_q, ov_d;
  logic              set_to, set_ov, clr_flags;
  logic [7:0]        wr_done_resp, wr_to_resp;

`ifdef SPI_REG_CTRL_WR_ECHO_EN
  assign wr_done_resp = ~wdata_q;
  assign wr_to_resp   = ERR_BYTE;
`else
  assign wr_done_resp = response_q;
  assign wr_to_resp   = response_q;
`endif

  always_comb begin
    state_d    = state_q;
    response_d = response_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    set_to     = 1'b0;
    set_ov     = 1'b0;
    clr_flags  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.cmd_valid) begin
          if (io.cmd[7]) begin
            addr_d  = io.cmd[ADDR_W-1:0];
            state_d = WAIT_DATA;
          end else if (io.cmd[6:0] == STATUS_ADDR) begin
            response_d = {6'b0, ov_q, to_q};
            clr_flags  = 1'b1;
          end else begin
            addr_d  = io.cmd[ADDR_W-1:0];
            we_d    = 1'b0;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = BUS_RD;
          end
        end
      end
      WAIT_DATA: begin
        // The byte after a write command is always data, even if it looks like a command.
        if (io.cmd_valid) begin
          if (addr_q == STATUS_ADDR) begin
            state_d = IDLE;
          end else begin
            wdata_d = io.cmd;
            we_d    = 1'b1;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = BUS_WR;
          end
        end
      end
      BUS_WR, BUS_RD: begin
        set_ov = io.cmd_valid;
        if (io.bus_ack) begin
          req_d      = 1'b0;
          state_d    = IDLE;
          response_d = (state_q == BUS_RD) ? io.bus_rdata : wr_done_resp;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          req_d      = 1'b0;
          set_to     = 1'b1;
          state_d    = IDLE;
          response_d = (state_q == BUS_RD) ? ERR_BYTE : wr_to_resp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A set event in the same cycle as a status-read clear keeps the flag.
    to_d = set_to | (to_q & ~clr_flags);
    ov_d = set_ov | (ov_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      response_q <= 8'h00;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      cnt_q      <= '0;
      to_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      response_q <= response_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      ov_q       <= ov_d;
    end
  end

  assign io.response    = response_q;
  assign io.bus_req     = req_q;
  assign io.bus_we      = we_q;
  assign io.bus_addr    = addr_q;
  assign io.bus_wdata   = wdata_q;
  assign io.busy        = (state_q != IDLE);
  assign io.err_timeout = to_q;
  assign io.err_overrun = ov_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: vector table through a scoreboard queue plus corner-case sequences.
module tb_spi_reg_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_reg_ctrl_if #(.ADDR_W(7)) io();

  spi_reg_ctrl dut (.clk(clk), .rst(rst), .io(io));

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] rdata;
    int         delay;
  } vec_t;

  typedef struct {
    logic       bus;
    logic [6:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] resp;
  } exp_t;

  exp_t       sb[$];
  vec_t       vecs[6];
  logic [7:0] model_resp;
  int         checks   = 0;
  int         failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    io.cmd       = b;
    io.cmd_valid = 1'b1;
    tick();
    io.cmd_valid = 1'b0;
  endtask

  task automatic ack(input logic [7:0] rd);
    io.bus_ack   = 1'b1;
    io.bus_rdata = rd;
    tick();
    io.bus_ack   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    e.addr  = v.cmd[6:0];
    e.we    = v.cmd[7];
    e.wdata = v.data;
    e.bus   = !(v.cmd[7] && v.cmd[6:0] == 7'h7F);
    if (!v.cmd[7])     e.resp = v.rdata;
    else if (!e.bus)   e.resp = model_resp;
    else begin
`ifdef SPI_REG_CTRL_WR_ECHO_EN
      e.resp = ~v.data;
`else
      e.resp = model_resp;
`endif
    end
    sb.push_back(e);
    send(v.cmd);
    if (v.cmd[7]) begin
      chk("wait_data_busy", io.busy, 1);
      chk("wait_data_noreq", io.bus_req, 0);
      send(v.data);
    end
    got = sb.pop_front();
    if (got.bus) begin
      chk("req_latency", io.bus_req, 1);
      chk("bus_addr", io.bus_addr, got.addr);
      chk("bus_we", io.bus_we, got.we);
      if (got.we) chk("bus_wdata", io.bus_wdata, got.wdata);
      repeat (v.delay) tick();
      chk("req_held", io.bus_req, 1);
      ack(v.rdata);
    end
    chk("req_dropped", io.bus_req, 0);
    chk("idle_busy", io.busy, 0);
    chk("response", io.response, got.resp);
    model_resp = got.resp;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_response"}, io.response, 0);
    chk({tag, "_req"}, io.bus_req, 0);
    chk({tag, "_we"}, io.bus_we, 0);
    chk({tag, "_addr"}, io.bus_addr, 0);
    chk({tag, "_wdata"}, io.bus_wdata, 0);
    chk({tag, "_busy"}, io.busy, 0);
    chk({tag, "_err_to"}, io.err_timeout, 0);
    chk({tag, "_err_ov"}, io.err_overrun, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{cmd: 8'h12, data: 8'h00, rdata: 8'hA7, delay: 1};
    vecs[1] = '{cmd: 8'h85, data: 8'h3C, rdata: 8'h00, delay: 3};
    vecs[2] = '{cmd: 8'h01, data: 8'h00, rdata: 8'h5A, delay: 0};
    vecs[3] = '{cmd: 8'h8A, data: 8'hFF, rdata: 8'h00, delay: 2};
    vecs[4] = '{cmd: 8'hFF, data: 8'h11, rdata: 8'h00, delay: 0};
    vecs[5] = '{cmd: 8'h33, data: 8'h00, rdata: 8'h00, delay: 5};

    io.cmd = 8'h00; io.cmd_valid = 1'b0; io.bus_ack = 1'b0; io.bus_rdata = 8'h00;
    model_resp = 8'h00;
    tick(); tick();
    rst = 1'b0;
    check_reset("reset");

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Read timeout: bus_req high for exactly ACK_TIMEOUT cycles.
    send(8'h20);
    n = 0;
    while (io.bus_req && n < 200) begin
      n++;
      tick();
    end
    chk("timeout_req_cycles", n, 64);
    chk("timeout_err", io.err_timeout, 1);
    chk("timeout_resp", io.response, 8'hEE);
    chk("timeout_busy", io.busy, 0);
    send(8'h7F);
    chk("status_after_to", io.response, 8'h01);
    chk("status_clears_to", io.err_timeout, 0);

    // Ack on the terminal-count cycle wins.
    send(8'h30);
    repeat (63) tick();
    chk("collision_req_high", io.bus_req, 1);
    ack(8'h9A);
    chk("collision_no_err", io.err_timeout, 0);
    chk("collision_resp", io.response, 8'h9A);
    chk("collision_req_low", io.bus_req, 0);

    // Overrun: second byte during a read is dropped.
    send(8'h10);
    send(8'h11);
    chk("overrun_flag", io.err_overrun, 1);
    chk("overrun_addr", io.bus_addr, 7'h10);
    chk("overrun_req", io.bus_req, 1);
    ack(8'h55);
    chk("overrun_resp", io.response, 8'h55);
    n = 0;
    repeat (5) begin
      tick();
      if (io.bus_req || io.busy) n++;
    end
    chk("overrun_single_txn", n, 0);
    send(8'h7F);
    chk("status_after_ov", io.response, 8'h02);
    chk("status_clears_ov", io.err_overrun, 0);

    // Byte arriving with bus_ack is still dropped.
    send(8'h40);
    io.cmd = 8'h85; io.cmd_valid = 1'b1; io.bus_ack = 1'b1; io.bus_rdata = 8'h66;
    tick();
    io.cmd_valid = 1'b0; io.bus_ack = 1'b0;
    chk("ack_ov_busy", io.busy, 0);
    chk("ack_ov_flag", io.err_overrun, 1);
    chk("ack_ov_resp", io.response, 8'h66);
    send(8'h7F);
    chk("status_ack_ov", io.response, 8'h02);

    // Reset in WAIT_DATA, then in BUS_RD.
    send(8'h85);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset("rst_wait");
    send(8'h12);
    chk("rst_rd_req", io.bus_req, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset("rst_rd");
    model_resp = 8'h00;
    run_vec('{cmd: 8'h85, data: 8'h3C, rdata: 8'h00, delay: 3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
